// File: rtl/prog_loader.sv
// Instruction-memory loader: assembles a MAGIC/count/data byte stream into
// 32-bit words written to imem from address 0, holding the CPU in reset meanwhile.
module prog_loader #(
  parameter logic [7:0]  MAGIC   = 8'hA5,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  logic [15:0]   count;
  logic [15:0]   waddr;
  logic [1:0]    idx;
  logic [31:0]   asm_word;
  logic [TW-1:0] tmo;

  logic accept_c;
  logic counting_c;
  logic tmo_hit_c;

  assign accept_c   = rx_valid && rx_ready;
  assign counting_c = (state == S_CNT_LO) || (state == S_CNT_HI) || (state == S_DATA);
  assign tmo_hit_c  = counting_c && !accept_c && (tmo == TMO_LAST);

  // Load sequencer; waddr tracks the next word so imem_addr can keep the last written one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= 16'd0;
      imem_wdata <= 32'd0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      count      <= 16'd0;
      waddr      <= 16'd0;
      idx        <= 2'd0;
      asm_word   <= 32'd0;
      tmo        <= '0;
    end else begin
      imem_we   <= 1'b0;
      load_done <= 1'b0;
      rx_ready  <= 1'b1;

      // Idle-gap counter: restarts on every accepted byte and outside the byte-waiting states.
      if (counting_c && !accept_c && !tmo_hit_c) begin
        tmo <= tmo + TW'(1);
      end else begin
        tmo <= '0;
      end

      case (state)
        S_IDLE: begin
          if (accept_c && rx_data == MAGIC) begin
            cpu_hold  <= 1'b1;
            load_err  <= 1'b0;
            imem_addr <= 16'd0;
            waddr     <= 16'd0;
            state     <= S_CNT_LO;
          end
        end

        S_CNT_LO: begin
          if (accept_c) begin
            count[7:0] <= rx_data;
            state      <= S_CNT_HI;
          end else if (tmo_hit_c) begin
            state <= S_ERR;
          end
        end

        S_CNT_HI: begin
          if (accept_c) begin
            count[15:8] <= rx_data;
            idx         <= 2'd0;
            if ({rx_data, count[7:0]} == 16'd0) begin
              load_done <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_DATA;
            end
          end else if (tmo_hit_c) begin
            state <= S_ERR;
          end
        end

        S_DATA: begin
          if (accept_c) begin
            asm_word[{idx, 3'b000} +: 8] <= rx_data;
            if (idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= waddr;
              imem_wdata <= {rx_data, asm_word[23:0]};
              rx_ready   <= 1'b0;
              state      <= S_WRITE;
            end else begin
              idx <= idx + 2'd1;
            end
          end else if (tmo_hit_c) begin
            state <= S_ERR;
          end
        end

        S_WRITE: begin
          waddr <= waddr + 16'd1;
          count <= count - 16'd1;
          idx   <= 2'd0;
          if (count == 16'd1) begin
            load_done <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_DATA;
          end
        end

        S_DONE: begin
          cpu_hold <= 1'b0;
          state    <= S_IDLE;
        end

        S_ERR: begin
          load_err <= 1'b1;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued by the stimulus,
// a negedge monitor pops and checks each imem write.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  prog_loader #(.MAGIC(8'hA5), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        got;
  logic [7:0] v[$];
  logic [31:0] words[8];
  int n_cmp     = 0;
  int n_err     = 0;
  int done_seen = 0;
  int exp_done  = 0;
  int wr_seen   = 0;
  int wr_base   = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Presents one byte and returns 1ns after the edge that accepted it.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!rx_ready) check("send_ready_timeout", 64'(rx_ready), 64'(1));
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_v();
    foreach (v[i]) send(v[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every write is matched against the scoreboard in order.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_seen++;
      check("write_rx_ready_low", 64'(rx_ready), 64'(0));
      check("write_cpu_hold", 64'(cpu_hold), 64'(1));
      check("write_done_exclusive", 64'(load_done), 64'(0));
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", imem_addr, imem_wdata);
      end else begin
        got = exp_q.pop_front();
        check("write_addr", 64'(imem_addr), 64'(got.addr));
        check("write_data", 64'(imem_wdata), 64'(got.data));
      end
    end
    if (load_done) begin
      done_seen++;
      check("done_single_cycle", 64'(prev_done), 64'(0));
    end
    prev_done <= load_done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    words = '{32'h00000013, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF,
              32'hFFFFFFFF, 32'h00000000, 32'h5A5A0F0F, 32'hC0FFEE11};
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(2);

    check("rst_rx_ready", 64'(rx_ready), 64'(1));
    check("rst_imem_we", 64'(imem_we), 64'(0));
    check("rst_imem_addr", 64'(imem_addr), 64'(0));
    check("rst_imem_wdata", 64'(imem_wdata), 64'(0));
    check("rst_cpu_hold", 64'(cpu_hold), 64'(0));
    check("rst_load_done", 64'(load_done), 64'(0));
    check("rst_load_err", 64'(load_err), 64'(0));
    rst_n = 1'b1;
    idle(1);

    // Two-word load
    push(16'd0, 32'h00000013);
    push(16'd1, 32'h00001237);
    send(8'hA5);
    check("t1_hold_after_magic", 64'(cpu_hold), 64'(1));
    v = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00};
    send_v();
    idle(4);
    exp_done++;
    check("t1_done_count", 64'(done_seen), 64'(exp_done));
    check("t1_hold_released", 64'(cpu_hold), 64'(0));
    check("t1_queue_drained", 64'(exp_q.size()), 64'(0));
    check("t1_no_err", 64'(load_err), 64'(0));

    // Junk before MAGIC, then a zero-length load
    v = '{8'h00, 8'hFF, 8'h5A};
    foreach (v[i]) begin
      send(v[i]);
      check("t2_junk_no_hold", 64'(cpu_hold), 64'(0));
    end
    wr_base = wr_seen;
    v = '{8'hA5, 8'h00, 8'h00};
    send_v();
    idle(4);
    exp_done++;
    check("t2_done_count", 64'(done_seen), 64'(exp_done));
    check("t2_no_writes", 64'(wr_seen), 64'(wr_base));
    check("t2_hold_released", 64'(cpu_hold), 64'(0));

    // Stall mid-word until timeout, then recover with a good load
    wr_base = wr_seen;
    v = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send_v();
    idle(24);
    check("t3_err_set", 64'(load_err), 64'(1));
    check("t3_hold_kept", 64'(cpu_hold), 64'(1));
    check("t3_no_writes", 64'(wr_seen), 64'(wr_base));
    check("t3_no_done", 64'(done_seen), 64'(exp_done));
    push(16'd0, 32'h12345678);
    send(8'hA5);
    check("t3_err_cleared", 64'(load_err), 64'(0));
    v = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_v();
    idle(4);
    exp_done++;
    check("t3_done_count", 64'(done_seen), 64'(exp_done));
    check("t3_hold_released", 64'(cpu_hold), 64'(0));
    check("t3_queue_drained", 64'(exp_q.size()), 64'(0));

    // Eight words with bursty rx_valid
    wr_base = wr_seen;
    for (int w = 0; w < 8; w++) push(16'(w), words[w]);
    v = '{8'hA5, 8'h08, 8'h00};
    send_v();
    for (int w = 0; w < 8; w++) begin
      for (int b = 0; b < 4; b++) begin
        int gap;
        gap = $urandom_range(0, 5);
        if (gap > 0) idle(gap);
        send(words[w][b*8 +: 8]);
      end
    end
    idle(4);
    exp_done++;
    check("t4_write_count", 64'(wr_seen - wr_base), 64'(8));
    check("t4_done_count", 64'(done_seen), 64'(exp_done));
    check("t4_queue_drained", 64'(exp_q.size()), 64'(0));

    // MAGIC inside the data is plain data
    push(16'd0, 32'hA5A5A5A5);
    push(16'd1, 32'h000000A5);
    push(16'd2, 32'hA5123400);
    v = '{8'hA5, 8'h03, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
          8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 8'hA5};
    send_v();
    idle(4);
    exp_done++;
    check("t5_done_count", 64'(done_seen), 64'(exp_done));
    check("t5_queue_drained", 64'(exp_q.size()), 64'(0));
    check("t5_hold_released", 64'(cpu_hold), 64'(0));

    // Asynchronous reset in the middle of the third word
    push(16'd0, 32'h01020304);
    push(16'd1, 32'h0A0B0C0D);
    v = '{8'hA5, 8'h03, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01,
          8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h77, 8'h66};
    send_v();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_rx_ready", 64'(rx_ready), 64'(1));
    check("t6_rst_imem_we", 64'(imem_we), 64'(0));
    check("t6_rst_imem_addr", 64'(imem_addr), 64'(0));
    check("t6_rst_imem_wdata", 64'(imem_wdata), 64'(0));
    check("t6_rst_cpu_hold", 64'(cpu_hold), 64'(0));
    check("t6_rst_load_err", 64'(load_err), 64'(0));
    check("t6_queue_drained", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    wr_base = wr_seen;
    v = '{8'h55, 8'h44, 8'h03, 8'h00, 8'h66, 8'h11};
    send_v();
    idle(6);
    check("t6_post_no_writes", 64'(wr_seen), 64'(wr_base));
    check("t6_post_no_hold", 64'(cpu_hold), 64'(0));
    check("t6_post_no_done", 64'(done_seen), 64'(exp_done));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
